// File: rtl/cpu_ctrl_seq.sv
// Control sequencer for the 4-bit SAP CPU: a one-hot T1..T6 ring drives fetch,
// then the IR opcode is decoded into per-T-state datapath strobes.
module cpu_ctrl_seq #(
  parameter bit EARLY_END = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] ir_op,
  input  logic       flag_c,
  input  logic       flag_z,
  output logic       ep,
  output logic       cp,
  output logic       lp,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       eu,
  output logic       su,
  output logic       lo,
  output logic       hlt,
  output logic [5:0] t_state
);

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } tstate_t;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'h3;
  localparam logic [3:0] OP_JMP = 4'h4;
  localparam logic [3:0] OP_JC  = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_LDI = 4'h7;
  localparam logic [3:0] OP_HLT = 4'hF;

  tstate_t state, state_nxt;
  logic    halted, halted_nxt;
  logic    multi_cycle;

  assign multi_cycle = (ir_op == OP_LDA) || (ir_op == OP_ADD) || (ir_op == OP_SUB);
  assign t_state     = state;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= T1;
      halted <= 1'b0;
    end else begin
      state  <= state_nxt;
      halted <= halted_nxt;
    end
  end

  // A halted sequencer parks in T4 until reset.
  always_comb begin
    state_nxt  = state;
    halted_nxt = halted;
    if (!halted) begin
      case (state)
        T1: state_nxt = T2;
        T2: state_nxt = T3;
        T3: state_nxt = T4;
        T4: begin
          if (ir_op == OP_HLT)
            halted_nxt = 1'b1;
          else if (EARLY_END && !multi_cycle)
            state_nxt = T1;
          else
            state_nxt = T5;
        end
        T5: begin
          if (EARLY_END && (ir_op == OP_LDA))
            state_nxt = T1;
          else
            state_nxt = T6;
        end
        T6: state_nxt = T1;
        default: state_nxt = T1;
      endcase
    end
  end

  // Strobes are masked by rst so they drop at once when reset is asserted.
  always_comb begin
    ep  = 1'b0;
    cp  = 1'b0;
    lp  = 1'b0;
    lm  = 1'b0;
    ce  = 1'b0;
    li  = 1'b0;
    ei  = 1'b0;
    la  = 1'b0;
    ea  = 1'b0;
    lb  = 1'b0;
    eu  = 1'b0;
    su  = 1'b0;
    lo  = 1'b0;
    hlt = 1'b0;
    if (rst) begin
      if (halted) begin
        hlt = 1'b1;
      end else begin
        case (state)
          T1: begin
            ep = 1'b1;
            lm = 1'b1;
          end
          T2: cp = 1'b1;
          T3: begin
            ce = 1'b1;
            li = 1'b1;
          end
          T4: begin
            case (ir_op)
              OP_LDA, OP_ADD, OP_SUB: begin
                ei = 1'b1;
                lm = 1'b1;
              end
              OP_OUT: begin
                ea = 1'b1;
                lo = 1'b1;
              end
              OP_JMP: begin
                ei = 1'b1;
                lp = 1'b1;
              end
              OP_JC: begin
                ei = flag_c;
                lp = flag_c;
              end
              OP_JZ: begin
                ei = flag_z;
                lp = flag_z;
              end
              OP_LDI: begin
                ei = 1'b1;
                la = 1'b1;
              end
              OP_HLT: hlt = 1'b1;
              default: ;
            endcase
          end
          T5: begin
            case (ir_op)
              OP_LDA: begin
                ce = 1'b1;
                la = 1'b1;
              end
              OP_ADD, OP_SUB: begin
                ce = 1'b1;
                lb = 1'b1;
              end
              default: ;
            endcase
          end
          T6: begin
            case (ir_op)
              OP_ADD: begin
                eu = 1'b1;
                la = 1'b1;
              end
              OP_SUB: begin
                eu = 1'b1;
                su = 1'b1;
                la = 1'b1;
              end
              default: ;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_seq.sv
// Bench for cpu_ctrl_seq: one instance per EARLY_END setting, each checked
// cycle by cycle against an opcode-table model of the SAP instruction set.
module tb_cpu_ctrl_seq;

  localparam int B_EP = 13, B_CP = 12, B_LP = 11, B_LM = 10, B_CE = 9, B_LI = 8, B_EI = 7;
  localparam int B_LA = 6, B_EA = 5, B_LB = 4, B_EU = 3, B_SU = 2, B_LO = 1, B_HLT = 0;

  logic       clk, rst;
  logic [3:0] a_op, b_op;
  logic       flag_c, flag_z;
  logic a_ep, a_cp, a_lp, a_lm, a_ce, a_li, a_ei, a_la, a_ea, a_lb, a_eu, a_su, a_lo, a_hlt;
  logic b_ep, b_cp, b_lp, b_lm, b_ce, b_li, b_ei, b_la, b_ea, b_lb, b_eu, b_su, b_lo, b_hlt;
  logic [5:0] a_t, b_t;
  logic [13:0] a_str, b_str;
  int tests = 0;
  int fails = 0;

  assign a_str = {a_ep, a_cp, a_lp, a_lm, a_ce, a_li, a_ei, a_la, a_ea, a_lb, a_eu, a_su, a_lo, a_hlt};
  assign b_str = {b_ep, b_cp, b_lp, b_lm, b_ce, b_li, b_ei, b_la, b_ea, b_lb, b_eu, b_su, b_lo, b_hlt};

  cpu_ctrl_seq #(.EARLY_END(1'b0)) dut_a (
    .clk(clk), .rst(rst), .ir_op(a_op), .flag_c(flag_c), .flag_z(flag_z),
    .ep(a_ep), .cp(a_cp), .lp(a_lp), .lm(a_lm), .ce(a_ce), .li(a_li), .ei(a_ei),
    .la(a_la), .ea(a_ea), .lb(a_lb), .eu(a_eu), .su(a_su), .lo(a_lo), .hlt(a_hlt),
    .t_state(a_t)
  );

  cpu_ctrl_seq #(.EARLY_END(1'b1)) dut_b (
    .clk(clk), .rst(rst), .ir_op(b_op), .flag_c(flag_c), .flag_z(flag_z),
    .ep(b_ep), .cp(b_cp), .lp(b_lp), .lm(b_lm), .ce(b_ce), .li(b_li), .ei(b_ei),
    .la(b_la), .ea(b_ea), .lb(b_lb), .eu(b_eu), .su(b_su), .lo(b_lo), .hlt(b_hlt),
    .t_state(b_t)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Strobe set expected in T-state t (1..6) for an opcode, straight from the instruction table.
  function automatic logic [13:0] exp_str(input logic [3:0] op, input int t, input logic fc, input logic fz);
    logic [13:0] s;
    s = '0;
    if (t == 1) begin
      s[B_EP] = 1'b1; s[B_LM] = 1'b1;
    end else if (t == 2) begin
      s[B_CP] = 1'b1;
    end else if (t == 3) begin
      s[B_CE] = 1'b1; s[B_LI] = 1'b1;
    end else begin
      case (op)
        4'h0: begin
          if (t == 4) begin s[B_EI] = 1'b1; s[B_LM] = 1'b1; end
          if (t == 5) begin s[B_CE] = 1'b1; s[B_LA] = 1'b1; end
        end
        4'h1, 4'h2: begin
          if (t == 4) begin s[B_EI] = 1'b1; s[B_LM] = 1'b1; end
          if (t == 5) begin s[B_CE] = 1'b1; s[B_LB] = 1'b1; end
          if (t == 6) begin s[B_EU] = 1'b1; s[B_LA] = 1'b1; s[B_SU] = (op == 4'h2); end
        end
        4'h3: if (t == 4) begin s[B_EA] = 1'b1; s[B_LO] = 1'b1; end
        4'h4: if (t == 4) begin s[B_EI] = 1'b1; s[B_LP] = 1'b1; end
        4'h5: if (t == 4 && fc) begin s[B_EI] = 1'b1; s[B_LP] = 1'b1; end
        4'h6: if (t == 4 && fz) begin s[B_EI] = 1'b1; s[B_LP] = 1'b1; end
        4'h7: if (t == 4) begin s[B_EI] = 1'b1; s[B_LA] = 1'b1; end
        4'hF: if (t == 4) s[B_HLT] = 1'b1;
        default: ;
      endcase
    end
    return s;
  endfunction

  function automatic int exp_len(input logic [3:0] op, input bit early);
    if (!early) return 6;
    if (op == 4'h0) return 5;
    if (op == 4'h1 || op == 4'h2) return 6;
    return 4;
  endfunction

  // Leaves both instances in T1 just after a falling edge.
  task automatic do_reset();
    rst = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      #1;
      tests++;
      if (a_str !== 14'd0 || b_str !== 14'd0) begin
        fails++;
        $display("[TB] FAIL reset_strobes: got a=%b b=%b expected 0", a_str, b_str);
      end
      tests++;
      if (a_t !== 6'b000001 || b_t !== 6'b000001) begin
        fails++;
        $display("[TB] FAIL reset_tstate: got a=%b b=%b expected 000001", a_t, b_t);
      end
    end
    @(negedge clk);
    rst = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      #1;
      tests++;
      if (a_str !== exp_str(4'h8, t, 1'b0, 1'b0) || a_t !== 6'(1 << (t - 1))) begin
        fails++;
        $display("[TB] FAIL reset_fetch t=%0d: got %b/%b expected %b/%b", t, a_str, a_t,
                 exp_str(4'h8, t, 1'b0, 1'b0), 6'(1 << (t - 1)));
      end
      @(negedge clk);
    end
  endtask

  // Runs n instructions on one instance; flags are random except where pinned in T4.
  task automatic test_program(input int sel, input int n, input logic [63:0] prog, input bit rnd_op,
                              input bit rnd_flags, input logic fc4, input logic fz4, input string name);
    logic [3:0]  op;
    logic [13:0] act, exp;
    logic [5:0]  ts;
    logic        fc, fz;
    int          len;
    do_reset();
    for (int i = 0; i < n; i++) begin
      op   = rnd_op ? 4'($urandom_range(0, 14)) : prog[i*4 +: 4];
      a_op = op;
      b_op = op;
      len  = exp_len(op, sel != 0);
      for (int t = 1; t <= len; t++) begin
        fc = 1'($urandom_range(0, 1));
        fz = 1'($urandom_range(0, 1));
        if (t == 4 && !rnd_flags) begin
          fc = fc4;
          fz = fz4;
        end
        flag_c = fc;
        flag_z = fz;
        #1;
        act = (sel != 0) ? b_str : a_str;
        ts  = (sel != 0) ? b_t : a_t;
        exp = exp_str(op, t, fc, fz);
        tests++;
        if (act !== exp) begin
          fails++;
          $display("[TB] FAIL %s strobes op=%h t=%0d: got %b expected %b", name, op, t, act, exp);
        end
        tests++;
        if (ts !== 6'(1 << (t - 1))) begin
          fails++;
          $display("[TB] FAIL %s tstate op=%h t=%0d: got %b expected %b", name, op, t, ts, 6'(1 << (t - 1)));
        end
        @(negedge clk);
      end
    end
    #1;
    ts = (sel != 0) ? b_t : a_t;
    tests++;
    if (ts !== 6'b000001) begin
      fails++;
      $display("[TB] FAIL %s wrap: got %b expected 000001", name, ts);
    end
  endtask

  task automatic test_halt(input int sel);
    logic [13:0] act, exp;
    logic [5:0]  ts;
    do_reset();
    a_op = 4'hF;
    b_op = 4'hF;
    for (int t = 1; t <= 4; t++) begin
      #1;
      act = (sel != 0) ? b_str : a_str;
      exp = exp_str(4'hF, t, flag_c, flag_z);
      tests++;
      if (act !== exp) begin
        fails++;
        $display("[TB] FAIL halt_entry sel=%0d t=%0d: got %b expected %b", sel, t, act, exp);
      end
      @(negedge clk);
    end
    repeat (10) begin
      a_op   = 4'($urandom_range(0, 15));
      b_op   = 4'($urandom_range(0, 15));
      flag_c = 1'($urandom_range(0, 1));
      flag_z = 1'($urandom_range(0, 1));
      #1;
      act = (sel != 0) ? b_str : a_str;
      ts  = (sel != 0) ? b_t : a_t;
      tests++;
      if (act !== 14'd1 || ts !== 6'b001000) begin
        fails++;
        $display("[TB] FAIL halt_hold sel=%0d: got %b/%b expected %b/001000", sel, act, ts, 14'd1);
      end
      @(negedge clk);
    end
    rst = 1'b0;
    #1;
    act = (sel != 0) ? b_str : a_str;
    ts  = (sel != 0) ? b_t : a_t;
    tests++;
    if (act !== 14'd0 || ts !== 6'b000001) begin
      fails++;
      $display("[TB] FAIL halt_clear sel=%0d: got %b/%b expected 0/000001", sel, act, ts);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    act = (sel != 0) ? b_str : a_str;
    tests++;
    if (act !== exp_str(4'h0, 1, 1'b0, 1'b0)) begin
      fails++;
      $display("[TB] FAIL halt_restart sel=%0d: got %b expected %b", sel, act, exp_str(4'h0, 1, 1'b0, 1'b0));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    a_op = 4'h1;
    repeat (4) @(negedge clk);
    #1;
    tests++;
    if (a_str !== exp_str(4'h1, 5, 1'b0, 1'b0) || a_t !== 6'b010000) begin
      fails++;
      $display("[TB] FAIL mid_t5: got %b/%b expected %b/010000", a_str, a_t, exp_str(4'h1, 5, 1'b0, 1'b0));
    end
    #1;
    rst = 1'b0;
    #1;
    tests++;
    if (a_str !== 14'd0 || a_t !== 6'b000001) begin
      fails++;
      $display("[TB] FAIL mid_drop: got %b/%b expected 0/000001", a_str, a_t);
    end
    @(negedge clk);
    rst = 1'b1;
    for (int t = 1; t <= 2; t++) begin
      #1;
      tests++;
      if (a_str !== exp_str(4'h1, t, 1'b0, 1'b0) || a_t !== 6'(1 << (t - 1))) begin
        fails++;
        $display("[TB] FAIL mid_refetch t=%0d: got %b/%b expected %b", t, a_str, a_t, exp_str(4'h1, t, 1'b0, 1'b0));
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst    = 1'b0;
    a_op   = 4'h0;
    b_op   = 4'h0;
    flag_c = 1'b0;
    flag_z = 1'b0;
    test_reset();
    test_program(0, 2, 64'h11, 1'b0, 1'b1, 1'b0, 1'b0, "add");
    test_program(0, 2, 64'h22, 1'b0, 1'b1, 1'b0, 1'b0, "sub");
    test_program(0, 1, 64'h5, 1'b0, 1'b0, 1'b1, 1'b0, "jc_taken");
    test_program(0, 1, 64'h5, 1'b0, 1'b0, 1'b0, 1'b1, "jc_not");
    test_program(0, 1, 64'h6, 1'b0, 1'b0, 1'b0, 1'b1, "jz_taken");
    test_program(0, 1, 64'h6, 1'b0, 1'b0, 1'b1, 1'b0, "jz_not");
    test_program(1, 2, 64'h65, 1'b0, 1'b0, 1'b0, 1'b1, "early_jumps");
    test_program(1, 3, 64'h430, 1'b0, 1'b1, 1'b0, 1'b0, "early_lda_out_jmp");
    test_program(0, 20, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, "random_full");
    test_program(1, 20, 64'h0, 1'b1, 1'b1, 1'b0, 1'b0, "random_early");
    test_halt(0);
    test_halt(1);
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
